// File: rtl/sqrt_result_reorder.sv
// rtl/sqrt_result_reorder.sv - tag issue and in-order retire of out-of-order worker results
module sqrt_result_reorder #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_req,
  output logic                       iss_rdy,
  output logic [$clog2(DEPTH)-1:0]   iss_tag,
  input  logic                       cpl_vld,
  input  logic [$clog2(DEPTH)-1:0]   cpl_tag,
  input  logic [W-1:0]               cpl_data,
  output logic                       res_vld,
  input  logic                       res_rdy,
  output logic [W-1:0]               res,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] done;
  logic [W-1:0]     mem [DEPTH];

  logic [AW-1:0]    cpl_off;
  logic             cpl_ok;
  logic             issue;
  logic             load;

  // DEPTH is a power of two and cnt never exceeds it, so the top bit alone means full.
  assign iss_rdy = ~cnt[AW];
  assign iss_tag = wr_ptr;
  assign issue   = iss_req & iss_rdy;

  // A tag is outstanding when its distance past the head is below the outstanding count.
  assign cpl_off = cpl_tag - rd_ptr;
  assign cpl_ok  = cpl_vld & ({1'b0, cpl_off} < cnt) & ~done[cpl_tag];
  assign load    = done[rd_ptr] & (cnt != '0) & (~res_vld | res_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({issue, load})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (cpl_vld & ~cpl_ok) begin
        err <= 1'b1;
      end
    end
  end

  // A legal completion can never target the head being loaded, since that tag is already done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
    end else begin
      if (load) begin
        done[rd_ptr] <= 1'b0;
      end
      if (cpl_ok) begin
        done[cpl_tag] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpl_ok) begin
      mem[cpl_tag] <= cpl_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld <= 1'b0;
      res     <= '0;
    end else if (load) begin
      res_vld <= 1'b1;
      res     <= mem[rd_ptr];
    end else if (res_rdy) begin
      res_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sqrt_result_reorder.sv
// tb/tb_sqrt_result_reorder.sv - queue-model scoreboard plus directed literal checks
module tb_sqrt_result_reorder;

  localparam int DEPTH = 64;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iss_req = 1'b0;
  logic          iss_rdy;
  logic [5:0]    iss_tag;
  logic          cpl_vld = 1'b0;
  logic [5:0]    cpl_tag = '0;
  logic [W-1:0]  cpl_data = '0;
  logic          res_vld;
  logic          res_rdy = 1'b0;
  logic [W-1:0]  res;
  logic [6:0]    cnt;
  logic          err;

  int n_total = 0;
  int n_pass  = 0;

  sqrt_result_reorder #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_tag(iss_tag),
    .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Model: outstanding tasks as an issue-ordered queue, plus the single output slot.
  typedef struct {
    int            tag;
    bit            done;
    logic [W-1:0]  data;
  } ent_t;

  ent_t         pend[$];
  int           m_tag = 0;
  bit           m_vld = 0;
  logic [W-1:0] m_res = '0;
  bit           m_err = 0;

  always @(negedge clk) begin
    int  sz0;
    bit  ld;
    bit  found;
    if (rst) begin
      pend.delete();
      m_tag = 0; m_vld = 0; m_res = '0; m_err = 0;
    end
    chk("m_res_vld", res_vld, m_vld);
    chk("m_res", res, m_res);
    chk("m_cnt", cnt, pend.size());
    chk("m_iss_rdy", iss_rdy, pend.size() != DEPTH);
    chk("m_iss_tag", iss_tag, m_tag);
    chk("m_err", err, m_err);
    if (!rst) begin
      sz0 = pend.size();
      ld  = (sz0 > 0) && pend[0].done && (!m_vld || res_rdy);
      if (cpl_vld) begin
        found = 0;
        foreach (pend[i]) begin
          if (pend[i].tag == int'(cpl_tag) && !pend[i].done) begin
            pend[i].done = 1;
            pend[i].data = cpl_data;
            found = 1;
          end
        end
        if (!found) m_err = 1;
      end
      if (ld) begin
        m_res = pend[0].data;
        m_vld = 1;
        void'(pend.pop_front());
      end else if (res_rdy) begin
        m_vld = 0;
      end
      if (iss_req && sz0 != DEPTH) begin
        pend.push_back('{tag: m_tag, done: 0, data: '0});
        m_tag = (m_tag + 1) % DEPTH;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    iss_req = 0; cpl_vld = 0; res_rdy = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic cpl(input int tag, input logic [W-1:0] d);
    cpl_vld = 1; cpl_tag = tag[5:0]; cpl_data = d;
  endtask

  initial begin
    // 1 Reset
    do_reset();
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_iss_rdy", iss_rdy, 1);
    chk("rst_iss_tag", iss_tag, 0);
    chk("rst_err", err, 0);

    // 2 In-order completions, result two cycles after the head completes
    iss_req = 1;
    for (int i = 0; i < 3; i++) begin
      chk("io_tag", iss_tag, i);
      tick();
    end
    iss_req = 0;
    chk("io_cnt3", cnt, 3);
    res_rdy = 1;
    cpl(0, 10); tick();
    chk("io_lat1", res_vld, 0);
    cpl(1, 20); tick();
    chk("io_r0_vld", res_vld, 1);
    chk("io_r0", res, 10);
    cpl(2, 30); tick();
    chk("io_r1", res, 20);
    cpl_vld = 0; tick();
    chk("io_r2", res, 30);
    chk("io_r2_vld", res_vld, 1);
    tick();
    chk("io_end_vld", res_vld, 0);
    chk("io_end_cnt", cnt, 0);

    // 3 Out-of-order completions
    do_reset();
    res_rdy = 1;
    iss_req = 1;
    repeat (4) tick();
    iss_req = 0;
    cpl(3, 'hD); tick(); chk("oo_wait3", res_vld, 0);
    cpl(1, 'hB); tick(); chk("oo_wait1", res_vld, 0);
    cpl(2, 'hC); tick(); chk("oo_wait2", res_vld, 0);
    cpl(0, 'hA); tick(); chk("oo_wait0", res_vld, 0);
    cpl_vld = 0; tick();
    chk("oo_a", res, 'hA);
    tick(); chk("oo_b", res, 'hB);
    tick(); chk("oo_c", res, 'hC);
    tick(); chk("oo_d", res, 'hD); chk("oo_d_vld", res_vld, 1);
    tick(); chk("oo_empty_vld", res_vld, 0); chk("oo_cnt0", cnt, 0);

    // 4 Full and backpressure
    do_reset();
    iss_req = 1;
    repeat (64) tick();
    chk("full_cnt", cnt, 64);
    chk("full_rdy", iss_rdy, 0);
    tick();
    chk("full_ignored_cnt", cnt, 64);
    chk("full_ignored_tag", iss_tag, 0);
    iss_req = 0;
    for (int t = 0; t < 64; t++) begin
      cpl(t, 1000 + t);
      tick();
    end
    cpl_vld = 0;
    chk("full_rdy_again", iss_rdy, 1);
    chk("full_cnt63", cnt, 63);
    repeat (3) begin
      tick();
      chk("hold_res", res, 1000);
      chk("hold_vld", res_vld, 1);
    end
    res_rdy = 1;
    tick();
    for (int k = 1; k < 64; k++) begin
      chk("drain_res", res, 1000 + k);
      tick();
    end
    chk("drain_vld", res_vld, 0);
    chk("drain_cnt", cnt, 0);
    chk("wrap_tag", iss_tag, 0);
    iss_req = 1; tick(); iss_req = 0;
    chk("wrap_next_tag", iss_tag, 1);

    // 5 Errors
    do_reset();
    cpl(5, 'h55); tick(); cpl_vld = 0;
    chk("err_empty", err, 1);
    tick();
    chk("err_empty_novld", res_vld, 0);
    do_reset();
    iss_req = 1; repeat (2) tick(); iss_req = 0;
    cpl(1, 'h11); tick();
    chk("dup_first_ok", err, 0);
    cpl(1, 'h22); tick();
    chk("dup_err", err, 1);
    res_rdy = 1;
    cpl(0, 'h33); tick(); cpl_vld = 0;
    tick(); chk("dup_r0", res, 'h33);
    tick(); chk("dup_r1_kept", res, 'h11);
    tick(); chk("dup_sticky", err, 1);

    // 6 Asynchronous reset mid-run
    do_reset();
    res_rdy = 1;
    iss_req = 1; repeat (10) tick(); iss_req = 0;
    cpl(2, 2); tick();
    cpl(3, 3); tick();
    cpl(4, 4); tick();
    cpl_vld = 0;
    chk("mid_cnt", cnt, 10);
    #2 rst = 1;
    #1;
    chk("mid_cnt0", cnt, 0);
    chk("mid_rdy", iss_rdy, 1);
    chk("mid_vld", res_vld, 0);
    chk("mid_tag", iss_tag, 0);
    tick();
    rst = 0;
    cpl(5, 'h77); tick(); cpl_vld = 0;
    chk("late_err", err, 1);
    tick();
    chk("late_novld", res_vld, 0);
    chk("late_cnt", cnt, 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
